hex_display_scheduler: RTL and testbench



---
 rtl/hex_display_scheduler_if.sv | 28 ++
 rtl/hex_display_scheduler.sv | 176 +++++++++++++++++
 tb/tb_hex_display_scheduler.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_scheduler_if.sv
// Write port for hex_display_scheduler: per-digit nibble writes
// with a valid/ready handshake plus a global clear pulse.
interface hex_display_scheduler_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_idx;
  logic [3:0] wr_data;
  logic       wr_blank;
  logic       clear;

  modport master (
    output wr_valid,
    output wr_idx,
    output wr_data,
    output wr_blank,
    output clear,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_idx,
    input  wr_data,
    input  wr_blank,
    input  clear,
    output wr_ready
  );
endinterface

// File: rtl/hex_display_scheduler.sv
// Shares one registered hex-to-7seg decoder across up to six
// displays, refreshing dirty digits in round-robin order.
module hex_display_scheduler #(
  parameter int NUM_DIGITS = 6
) (
  input  logic       clk,
  input  logic       reset,
  hex_display_scheduler_if.slave wr,
  output logic       busy,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE
  } state_t;

  localparam logic [3:0] LP_N    = 4'(NUM_DIGITS);
  localparam logic [2:0] LP_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [6:0] LP_OFF  = 7'h7F;

  logic [3:0] r_val [6];
  logic [5:0] r_blk;
  logic [5:0] r_dirty;
  state_t     r_state;
  logic [2:0] r_sel;
  logic [2:0] r_last;
  logic       r_blank_p;
  logic [6:0] r_dec;
  logic [6:0] r_hex [6];

  logic       w_acc;
  logic       w_wr_ok;
  logic       w_any;
  logic [2:0] w_next;
  logic [3:0] w_cur_val;
  logic       w_cur_blk;

  function automatic logic [2:0] f_next(
    input logic [5:0] m,
    input logic [2:0] last
  );
    logic found;
    int   j;
    f_next = last;
    found  = 1'b0;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      j = (int'(last) + k) % NUM_DIGITS;
      if (!found && m[3'(j)]) begin
        f_next = 3'(j);
        found  = 1'b1;
      end
    end
  endfunction

  // Active-low segments, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] f_seg(input logic [3:0] v);
    unique case (v)
      4'h0: f_seg = 7'h40;
      4'h1: f_seg = 7'h79;
      4'h2: f_seg = 7'h24;
      4'h3: f_seg = 7'h30;
      4'h4: f_seg = 7'h19;
      4'h5: f_seg = 7'h12;
      4'h6: f_seg = 7'h02;
      4'h7: f_seg = 7'h78;
      4'h8: f_seg = 7'h00;
      4'h9: f_seg = 7'h10;
      4'hA: f_seg = 7'h08;
      4'hB: f_seg = 7'h03;
      4'hC: f_seg = 7'h46;
      4'hD: f_seg = 7'h21;
      4'hE: f_seg = 7'h06;
      default: f_seg = 7'h0E;
    endcase
  endfunction

  assign wr.wr_ready = ~reset & ~wr.clear;
  assign w_acc       = wr.wr_valid & wr.wr_ready;
  assign w_wr_ok     = w_acc & ({1'b0, wr.wr_idx} < LP_N);
  assign w_any       = |r_dirty;
  assign w_next      = f_next(r_dirty, r_last);
  assign busy        = w_any | (r_state != S_IDLE);

  always_comb begin
    w_cur_val = 4'h0;
    w_cur_blk = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_sel == 3'(i)) begin
        w_cur_val = r_val[i];
        w_cur_blk = r_blk[i];
      end
    end
  end

  // A write or clear landing on the ISSUE edge keeps the digit dirty.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        r_val[i]   <= 4'h0;
        r_blk[i]   <= 1'b1;
        r_dirty[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr.clear) begin
          r_val[i]   <= 4'h0;
          r_blk[i]   <= 1'b1;
          r_dirty[i] <= 1'b1;
        end else if (w_wr_ok && wr.wr_idx == 3'(i)) begin
          r_val[i]   <= wr.wr_data;
          r_blk[i]   <= wr.wr_blank;
          r_dirty[i] <= 1'b1;
        end else if (r_state == S_ISSUE && r_sel == 3'(i)) begin
          r_dirty[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sel     <= 3'd0;
      r_last    <= LP_LAST;
      r_blank_p <= 1'b1;
      r_dec     <= LP_OFF;
      for (int i = 0; i < 6; i++) begin
        r_hex[i] <= LP_OFF;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel   <= w_next;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_dec     <= f_seg(w_cur_val);
          r_blank_p <= w_cur_blk;
          r_last    <= r_sel;
          r_state   <= S_CAPTURE;
        end
        S_CAPTURE: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_sel == 3'(i)) begin
              r_hex[i] <= r_blank_p ? LP_OFF : r_dec;
            end
          end
          if (w_any) begin
            r_sel   <= w_next;
            r_state <= S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign HEX0 = r_hex[0];
  assign HEX1 = r_hex[1];
  assign HEX2 = r_hex[2];
  assign HEX3 = r_hex[3];
  assign HEX4 = r_hex[4];
  assign HEX5 = r_hex[5];

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler: a 6-digit and a
// 4-digit instance with hand-computed segment patterns.
module tb_hex_display_scheduler;

  logic clk;
  logic reset;
  logic busy6, busy4;
  logic [6:0] h0, h1, h2, h3, h4, h5;
  logic [6:0] g0, g1, g2, g3, g4, g5;
  int n_chk;
  int n_fail;

  hex_display_scheduler_if u_if  ();
  hex_display_scheduler_if u_if4 ();

  hex_display_scheduler #(.NUM_DIGITS(6)) u_dut (
    .clk  (clk),
    .reset(reset),
    .wr   (u_if.slave),
    .busy (busy6),
    .HEX0 (h0),
    .HEX1 (h1),
    .HEX2 (h2),
    .HEX3 (h3),
    .HEX4 (h4),
    .HEX5 (h5)
  );

  hex_display_scheduler #(.NUM_DIGITS(4)) u_dut4 (
    .clk  (clk),
    .reset(reset),
    .wr   (u_if4.slave),
    .busy (busy4),
    .HEX0 (g0),
    .HEX1 (g1),
    .HEX2 (g2),
    .HEX3 (g3),
    .HEX4 (g4),
    .HEX5 (g5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr6(input logic [2:0] idx, input logic [3:0] d,
                     input logic b);
    u_if.wr_valid = 1'b1;
    u_if.wr_idx   = idx;
    u_if.wr_data  = d;
    u_if.wr_blank = b;
    tick();
    u_if.wr_valid = 1'b0;
  endtask

  task automatic wr4(input logic [2:0] idx, input logic [3:0] d,
                     input logic b);
    u_if4.wr_valid = 1'b1;
    u_if4.wr_idx   = idx;
    u_if4.wr_data  = d;
    u_if4.wr_blank = b;
    tick();
    u_if4.wr_valid = 1'b0;
  endtask

  task automatic chk_all6(input string tag, input logic [41:0] exp);
    chk({tag, "_h0"}, {25'd0, h0}, {25'd0, exp[6:0]});
    chk({tag, "_h1"}, {25'd0, h1}, {25'd0, exp[13:7]});
    chk({tag, "_h2"}, {25'd0, h2}, {25'd0, exp[20:14]});
    chk({tag, "_h3"}, {25'd0, h3}, {25'd0, exp[27:21]});
    chk({tag, "_h4"}, {25'd0, h4}, {25'd0, exp[34:28]});
    chk({tag, "_h5"}, {25'd0, h5}, {25'd0, exp[41:35]});
  endtask

  localparam logic [6:0] OFF = 7'h7F;

  initial begin
    logic saw8;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    u_if.wr_valid  = 1'b0;
    u_if.wr_idx    = 3'd0;
    u_if.wr_data   = 4'h0;
    u_if.wr_blank  = 1'b0;
    u_if.clear     = 1'b0;
    u_if4.wr_valid = 1'b0;
    u_if4.wr_idx   = 3'd0;
    u_if4.wr_data  = 4'h0;
    u_if4.wr_blank = 1'b0;
    u_if4.clear    = 1'b0;
    tick();
    tick();
    chk("rst_ready", {31'd0, u_if.wr_ready}, 32'd0);
    chk_all6("rst", {OFF, OFF, OFF, OFF, OFF, OFF});
    chk("rst_busy", {31'd0, busy6}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready", {31'd0, u_if.wr_ready}, 32'd1);

    // 1: single write, HEX0 at N+3
    wr6(3'd0, 4'hA, 1'b0);
    chk("t1_busyN", {31'd0, busy6}, 32'd1);
    tick();
    tick();
    chk("t1_h0_n2", {25'd0, h0}, {25'd0, OFF});
    tick();
    chk_all6("t1", {OFF, OFF, OFF, OFF, OFF, 7'h08});
    chk("t1_busy", {31'd0, busy6}, 32'd0);

    // 2: six writes, index-order refresh
    for (int i = 0; i < 6; i++) wr6(3'(i), 4'(i), 1'b0);
    chk("t2_h1_e5", {25'd0, h1}, 32'h79);
    chk("t2_h2_e5", {25'd0, h2}, {25'd0, OFF});
    tick();
    tick();
    chk("t2_h2_e7", {25'd0, h2}, 32'h24);
    chk("t2_h3_e7", {25'd0, h3}, {25'd0, OFF});
    for (int i = 0; i < 5; i++) tick();
    chk("t2_busy_e12", {31'd0, busy6}, 32'd1);
    tick();
    chk("t2_busy_e13", {31'd0, busy6}, 32'd0);
    chk_all6("t2", {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40});

    // 3: overwrite during ISSUE
    wr6(3'd2, 4'h7, 1'b0);
    tick();
    wr6(3'd2, 4'hF, 1'b0);
    tick();
    chk("t3_h2_first", {25'd0, h2}, 32'h78);
    chk("t3_busy_f3", {31'd0, busy6}, 32'd1);
    tick();
    chk("t3_h2_f4", {25'd0, h2}, 32'h78);
    tick();
    chk("t3_h2_final", {25'd0, h2}, 32'h0E);
    chk("t3_busy_f5", {31'd0, busy6}, 32'd0);
    tick();
    tick();
    chk("t3_h2_hold", {25'd0, h2}, 32'h0E);
    chk("t3_busy_hold", {31'd0, busy6}, 32'd0);

    // 4: clear with a simultaneous write to idx 1
    u_if.clear    = 1'b1;
    u_if.wr_valid = 1'b1;
    u_if.wr_idx   = 3'd1;
    u_if.wr_data  = 4'h8;
    u_if.wr_blank = 1'b0;
    #1;
    chk("t4_ready", {31'd0, u_if.wr_ready}, 32'd0);
    tick();
    u_if.clear    = 1'b0;
    u_if.wr_valid = 1'b0;
    saw8 = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (h1 == 7'h00) saw8 = 1'b1;
    end
    chk("t4_no8", {31'd0, saw8}, 32'd0);
    chk_all6("t4", {OFF, OFF, OFF, OFF, OFF, OFF});
    chk("t4_busy", {31'd0, busy6}, 32'd0);

    // 5: blank then unblank, out-of-range index
    wr6(3'd3, 4'h5, 1'b1);
    tick();
    tick();
    tick();
    chk("t5_h3_blank", {25'd0, h3}, {25'd0, OFF});
    chk("t5_busy_a", {31'd0, busy6}, 32'd0);
    wr6(3'd3, 4'h5, 1'b0);
    tick();
    tick();
    tick();
    chk("t5_h3_five", {25'd0, h3}, 32'h12);
    wr6(3'd6, 4'h9, 1'b0);
    chk("t5_busy_idx6", {31'd0, busy6}, 32'd0);
    tick();
    tick();
    tick();
    chk_all6("t5", {OFF, OFF, 7'h12, OFF, OFF, OFF});

    // 6: four-digit instance
    wr4(3'd5, 4'h3, 1'b0);
    chk("t6_busy_idx5", {31'd0, busy4}, 32'd0);
    wr4(3'd0, 4'h1, 1'b0);
    tick();
    tick();
    tick();
    chk("t6_g0", {25'd0, g0}, 32'h79);
    chk("t6_g5", {25'd0, g5}, {25'd0, OFF});
    chk("t6_g4", {25'd0, g4}, {25'd0, OFF});
    wr4(3'd3, 4'h3, 1'b0);
    tick();
    tick();
    chk("t6_busy_cap", {31'd0, busy4}, 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_g0", {25'd0, g0}, {25'd0, OFF});
    chk("t6_rst_g3", {25'd0, g3}, {25'd0, OFF});
    chk("t6_rst_busy", {31'd0, busy4}, 32'd0);
    reset = 1'b0;
    tick();
    tick();
    chk("t6_post_g3", {25'd0, g3}, {25'd0, OFF});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
